sli_pattern_pipe: RTL
=====================

# sli_pattern_pipe

Parametrised structured-light pattern generator that sits between the HDMI/DVI input timing stage and the output encoder. It replaces active pixels with phase-shifted binary stripe patterns, horizontal or vertical, followed by a black/white flash phase. The sequence advances only when camera-ready credits are available. The whole block runs in one pixel-clock domain: sync edges, the `rdy` GPIO and switch inputs are all sampled and edge-detected on `clk`, with no clocking from `in_vsync` or `in_hsync`.

## Interface
Parameters:
- `DW`, 8: bits per colour channel.
- `FRA_LOG2`, 3: log2 of phase steps per frequency (N_FRA = 8).
- `N_FRQ`, 4: number of frequency groups. The last group is the flash group.
- `PER_LOG2`, 7: log2 of stripe period in pixels for frequency 0. Frequency f uses period 2^(PER_LOG2−f). Requires PER_LOG2−(N_FRQ−2) ≥ FRA_LOG2.
- `CW`, 10: width of the row and column counters and of the `rdy` credit counter.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 1: 1 = pattern mode, 0 = pass-through.
- `sw_ori` in 1: 1 = horizontal stripes (index by row), 0 = vertical stripes (index by column).
- `sw_ch_en` in 3: {R,G,B} channel enables.
- `rdy` in 1: camera-ready GPIO, asynchronous.
- `in_r`, `in_g`, `in_b` in DW: input pixel.
- `in_blank`, `in_hsync`, `in_vsync` in 1: input timing, all active-high.
- `out_r`, `out_g`, `out_b` out DW: output pixel.
- `out_blank`, `out_hsync`, `out_vsync` out 1: timing, delayed to match the pixel path.
- `trig` out 1: camera trigger.
- `f_frm` out 1: high while the first pattern (frq=0, fra=0) is displayed.
- `frq_idx` out ⌈log2 N_FRQ⌉: current frequency index.
- `fra_idx` out FRA_LOG2: current phase index.

## Operation
- **Edge detection.** `vs_rise` = in_vsync & ~vsync_d and `hs_rise` = in_hsync & ~hsync_d, both computed on `clk`.
- **rdy path.** `rdy` passes through a 2-flop synchroniser, then rising-edge detection produces `rdy_rise`.
- **Frame FSM.** States V, B, O; reset state is O.
  - V → B when in_vsync = 0.
  - B → O on the first cycle with in_blank = 0.
  - O → V on vs_rise.
- **Row counter.** Cleared in V and B. In O it increments on each hs_rise, and is held at 2^CW−1 once it saturates.
- **Column counter.** Cleared while in_blank = 1, otherwise increments by 1 per cycle, so the first active pixel has col = 0.
- **Switch latching.** `ori`, `ori_prev` and the channel enables are latched on vs_rise only. Mid-frame switch changes have no effect.
- **Credit counter.**
  - credit_next = credit + rdy_rise − (vs_rise & advance).
  - It saturates at 2^CW−1 and never goes below 0.
  - A coincident rdy_rise is counted before the advance decision is made. With credit = 0 plus a simultaneous edge, the frame advances and credit stays 0.
- **Sequence update on vs_rise**, in priority order:
  1. If mode = 0, or ori ≠ ori_prev: set frq = 0, fra = 0, hold = 1.
  2. Else if (credit + rdy_rise) > 0: advance = 1 and hold = 0. fra increments and wraps to 0 after N_FRA−1. On that wrap, frq increments and wraps to 0 after N_FRQ−1.
  3. Else: hold = 1, indices unchanged.
- **Pattern.** Let c = ori ? row : col, f = frq, P = 2^(PER_LOG2−f), s = fra·(P>>FRA_LOG2).
  - For f < N_FRQ−1: pix = ((c + s) mod P) < P/2 ? all-ones : 0.
  - For f = N_FRQ−1: pix = fra[0] ? all-ones : 0.
  - All arithmetic is unsigned and the modulo is a bit-mask.
- **Output pixel.**
  - If mode = 0 or in_blank = 1: pass the input through.
  - Otherwise, each channel is pix if that channel is enabled, else 0.
- **Trigger.** trig = (state == V) & (mode ? ~hold : flag). trig = 0 in B and O.

## Timing
- Pixel latency is 1 cycle. in_* at cycle n appears on out_* at n+1, and all three sync/blank outputs are delayed by 1 cycle.
- trig is registered: it rises 1 cycle after the FSM enters V.
- rdy_rise lands 3 cycles after a clean `rdy` rising edge.
- The new frq/fra take effect from the cycle after vs_rise, and are stable for the whole following active frame.
- Reset values:
  - Outputs: out_* = 0, trig = 0, f_frm = 1, frq_idx = 0, fra_idx = 0.
  - Internal: credit = 0, hold = 1, flag = 0, state = O.
- Reset asserted mid-frame clears everything immediately. Normal output resumes at the next vs_rise.

## Configuration
- `SLI_PASSTHRU_FLAG_EN` defined:
  - On the B→O transition, the block compares in_r with the stored top-left value TL.
  - If they differ, it sets flag = 1 and updates TL. If they are equal, flag = 0.
  - In pass-through mode this makes trig fire on content change.
- Undefined: flag is tied to 0, TL logic is absent, and trig is always 0 when mode = 0.

## Test plan
- Reset, then a 1280×720 frame in mode = 1 with no rdy -> frq = fra = 0 held for all frames, trig = 0, f_frm = 1, vertical stripes 64 px 0xFF / 64 px 0x00.
- One rdy pulse per frame for 32 frames -> fra cycles 0–7 for each frq. At frq = 1, fra = 1 the shift is 8 px. Frames 24–31 flash, giving 0x00 at even fra and 0xFF at odd fra. Index wraps to 0 at frame 32. trig pulses once per V.
- rdy rising edge on the same cycle as vs_rise with credit = 0 -> advance happens and credit stays 0. Then 3 rdy pulses during one frame -> 3 consecutive advances with no further pulses.
- Toggle sw_ori mid-frame -> no change in the current frame; at the next vs_rise indices reset to 0 and horizontal stripes are indexed by row.
- mode = 0 with in_r top-left changing 0x10→0x20 -> output equals input, with `SLI_PASSTHRU_FLAG_EN` trig high for that V period only. sw_ch_en = 3'b100 in mode = 1 -> G = B = 0.
- Assert rst mid-line -> all outputs go to their reset values within the same cycle (asynchronously, not waiting for a clk edge), and the pattern restarts at frq = fra = 0.

Source files
------------

// File: rtl/sli_pattern_pipe.sv
// Structured-light pattern generator between the input timing stage and the output encoder.
// Replaces active pixels with phase-shifted binary stripes (vertical or horizontal), followed by a
// black/white flash group. The sequence advances one step per frame only when camera-ready credits
// are available. Single clock domain: sync edges, rdy and switches are all sampled on clk.
// Optional feature macro: SLI_PASSTHRU_FLAG_EN (content-change trigger in pass-through mode).
module sli_pattern_pipe #(
  parameter int unsigned DW       = 8,
  parameter int unsigned FRA_LOG2 = 3,
  parameter int unsigned N_FRQ    = 4,
  parameter int unsigned PER_LOG2 = 7,
  parameter int unsigned CW       = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       sw_ori,
  input  logic [2:0]                 sw_ch_en,
  input  logic                       rdy,
  input  logic [DW-1:0]              in_r,
  input  logic [DW-1:0]              in_g,
  input  logic [DW-1:0]              in_b,
  input  logic                       in_blank,
  input  logic                       in_hsync,
  input  logic                       in_vsync,
  output logic [DW-1:0]              out_r,
  output logic [DW-1:0]              out_g,
  output logic [DW-1:0]              out_b,
  output logic                       out_blank,
  output logic                       out_hsync,
  output logic                       out_vsync,
  output logic                       trig,
  output logic                       f_frm,
  output logic [$clog2(N_FRQ)-1:0]   frq_idx,
  output logic [FRA_LOG2-1:0]        fra_idx
);

  localparam int unsigned FQW = $clog2(N_FRQ);

  typedef enum logic [1:0] {StV, StB, StO} state_e;

  state_e                state_q, state_d;
  logic                  vsync_q, hsync_q;
  logic                  rdy_s1_q, rdy_s2_q, rdy_s3_q;
  logic                  vs_rise, hs_rise, rdy_rise;
  logic [CW-1:0]         row_q, col_q;
  logic                  ori_q;
  logic [2:0]            ch_en_q;
  logic [CW-1:0]         credit_q, credit_d;
  logic [CW:0]           avail, cred_tmp;
  logic                  advance, ori_chg;
  logic [FQW-1:0]        frq_q, frq_d;
  logic [FRA_LOG2-1:0]   fra_q, fra_d;
  logic                  hold_q, hold_d;
  logic                  flag_q;
  int unsigned           per_sh;
  logic [CW-1:0]         pat_c, pat_p, pat_s, pat_m;
  logic                  pix_on;
  logic [DW-1:0]         pix;

  assign vs_rise  = in_vsync & ~vsync_q;
  assign hs_rise  = in_hsync & ~hsync_q;
  assign rdy_rise = rdy_s2_q & ~rdy_s3_q;

  // Sync delay for edge detection and 2-flop rdy synchroniser plus edge stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      rdy_s1_q <= 1'b0;
      rdy_s2_q <= 1'b0;
      rdy_s3_q <= 1'b0;
    end else begin
      vsync_q  <= in_vsync;
      hsync_q  <= in_hsync;
      rdy_s1_q <= rdy;
      rdy_s2_q <= rdy_s1_q;
      rdy_s3_q <= rdy_s2_q;
    end
  end

  // Frame FSM next state: V (vsync), B (back porch), O (active/other)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StV:     if (!in_vsync) state_d = StB;
      StB:     if (!in_blank) state_d = StO;
      StO:     if (vs_rise)   state_d = StV;
      default: state_d = StO;
    endcase
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StO;
    else     state_q <= state_d;
  end

  // Row/column counters; row saturates, column wraps (period divides 2^CW)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      if (state_q != StO)           row_q <= '0;
      else if (hs_rise && row_q != '1) row_q <= row_q + 1'b1;
      if (in_blank) col_q <= '0;
      else          col_q <= col_q + 1'b1;
    end
  end

  // Orientation change is judged against the value about to be latched at this vs_rise
  assign ori_chg = (sw_ori != ori_q);
  // rdy_rise is counted before the advance decision
  assign avail   = {1'b0, credit_q} + {{CW{1'b0}}, rdy_rise};

  // Sequence update and credit bookkeeping
  always_comb begin
    frq_d   = frq_q;
    fra_d   = fra_q;
    hold_d  = hold_q;
    advance = 1'b0;
    if (vs_rise) begin
      if (!mode || ori_chg) begin
        frq_d  = '0;
        fra_d  = '0;
        hold_d = 1'b1;
      end else if (avail != '0) begin
        advance = 1'b1;
        hold_d  = 1'b0;
        fra_d   = fra_q + 1'b1;
        if (fra_q == '1) frq_d = (frq_q == FQW'(N_FRQ - 1)) ? '0 : frq_q + 1'b1;
      end else begin
        hold_d = 1'b1;
      end
    end
    cred_tmp = avail - {{CW{1'b0}}, advance};
    credit_d = cred_tmp[CW] ? '1 : cred_tmp[CW-1:0];
  end

  // Sequence, credit and latched-switch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frq_q    <= '0;
      fra_q    <= '0;
      hold_q   <= 1'b1;
      credit_q <= '0;
      ori_q    <= 1'b0;
      ch_en_q  <= 3'b111;
    end else begin
      frq_q    <= frq_d;
      fra_q    <= fra_d;
      hold_q   <= hold_d;
      credit_q <= credit_d;
      if (vs_rise) begin
        ori_q   <= sw_ori;
        ch_en_q <= sw_ch_en;
      end
    end
  end

`ifdef SLI_PASSTHRU_FLAG_EN
  logic [DW-1:0] tl_q;

  // Compare the top-left pixel with the previous frame's at the start of active video
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
      tl_q   <= '0;
    end else if (state_q == StB && !in_blank) begin
      if (in_r != tl_q) begin
        flag_q <= 1'b1;
        tl_q   <= in_r;
      end else begin
        flag_q <= 1'b0;
      end
    end
  end
`else
  assign flag_q = 1'b0;
`endif

  // Stripe pattern: bit-mask modulo over period P = 2^(PER_LOG2-frq), shifted by fra*P/N_FRA
  always_comb begin
    per_sh = PER_LOG2 - 32'(frq_q);
    pat_c  = ori_q ? row_q : col_q;
    pat_p  = CW'(1) << per_sh;
    pat_s  = CW'(fra_q) << (per_sh - FRA_LOG2);
    pat_m  = (pat_c + pat_s) & (pat_p - CW'(1));
    pix_on = (pat_m < (pat_p >> 1));
    if (frq_q == FQW'(N_FRQ - 1)) pix_on = fra_q[0];
    pix = {DW{pix_on}};
  end

  // Registered pixel/timing outputs and trigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_blank <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      trig      <= 1'b0;
    end else begin
      out_blank <= in_blank;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
      if (!mode || in_blank) begin
        out_r <= in_r;
        out_g <= in_g;
        out_b <= in_b;
      end else begin
        out_r <= ch_en_q[2] ? pix : '0;
        out_g <= ch_en_q[1] ? pix : '0;
        out_b <= ch_en_q[0] ? pix : '0;
      end
      trig <= (state_q == StV) & (mode ? ~hold_q : flag_q);
    end
  end

  assign f_frm   = (frq_q == '0) && (fra_q == '0);
  assign frq_idx = frq_q;
  assign fra_idx = fra_q;

endmodule
